mac_array_sequencer: RTL and testbench

- Controller that sequences one complete matrix product through mac_array.
- Streams in operand matrices A (H x K) and B (K x W) over one valid/ready port and buffers them.
- Feeds the array's row/column lanes with diagonal skew, waits for every MAC result, then drains C = A*B in row-major order over a valid/yumi port.
- Clears the array with a one-cycle reset pulse at the end of each job. Replaces the hardcoded one-hot input driver and fixed 2x2 output mux with a fully parameterised scheduler.

---
 rtl/mac_pkg.sv | 23 ++
 rtl/mac_array_sequencer_if.sv | 30 +++
 rtl/operand_buffer.sv | 21 ++
 rtl/mac_array_sequencer.sv | 99 +++++++++
 tb/tb_mac_array_sequencer.sv | 328 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mac_pkg.sv
// mac_pkg: sequencer state encoding plus size helpers (MAC count, operand count, feed steps, counter width)
package mac_pkg;
  typedef enum logic [5:0] {
    IDLE  = 6'b000001,
    LOAD  = 6'b000010,
    FEED  = 6'b000100,
    WAIT  = 6'b001000,
    DRAIN = 6'b010000,
    CLEAR = 6'b100000
  } state_e;
  function automatic int num_macs(int h, int w);
    return h * w;
  endfunction
  function automatic int num_operands(int h, int w, int k);
    return h * k + k * w;
  endfunction
  function automatic int num_steps(int h, int w, int k);
    return k + (h > w ? h : w) - 1;
  endfunction
  function automatic int cnt_width(int max_v);
    return max_v < 1 ? 1 : $clog2(max_v + 1);
  endfunction
endpackage

// File: rtl/mac_array_sequencer_if.sv
// mac_array_sequencer_if: operand in (valid/ready), result out (valid/yumi), row/col lanes and MAC results; slave=sequencer, master=environment
interface mac_array_sequencer_if #(
  parameter int width_p = 32,
  parameter int array_width_p = 2,
  parameter int array_height_p = 2
);
  logic ready_o;
  logic valid_i;
  logic [width_p-1:0] data_i;
  logic valid_o;
  logic yumi_i;
  logic [width_p-1:0] data_o;
  logic [width_p*array_height_p-1:0] row_o;
  logic [array_height_p-1:0] row_valid_o;
  logic [array_height_p-1:0] row_ready_i;
  logic [width_p*array_width_p-1:0] col_o;
  logic [array_width_p-1:0] col_valid_o;
  logic [array_width_p-1:0] col_ready_i;
  logic [width_p*array_height_p*array_width_p-1:0] z_i;
  logic [array_height_p*array_width_p-1:0] z_valid_i;
  logic [array_height_p*array_width_p-1:0] z_yumi_o;
  modport slave (
    output ready_o, valid_o, data_o, row_o, row_valid_o, col_o, col_valid_o, z_yumi_o,
    input valid_i, data_i, yumi_i, row_ready_i, col_ready_i, z_i, z_valid_i
  );
  modport master (
    input ready_o, valid_o, data_o, row_o, row_valid_o, col_o, col_valid_o, z_yumi_o,
    output valid_i, data_i, yumi_i, row_ready_i, col_ready_i, z_i, z_valid_i
  );
endinterface

// File: rtl/operand_buffer.sv
// operand_buffer: words_p-word register file; ports clk_i/reset_i, write port we_i/idx_i/data_i, all words read flat on words_o
module operand_buffer #(
  parameter int width_p = 32,
  parameter int words_p = 8,
  parameter int idx_w_p = 3
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic we_i,
  input  logic [idx_w_p-1:0] idx_i,
  input  logic [width_p-1:0] data_i,
  output logic [width_p*words_p-1:0] words_o
);
  logic [width_p*words_p-1:0] mem_q, mem_d;
  always_comb begin
    mem_d = mem_q;
    if (we_i) mem_d[int'(idx_i)*width_p +: width_p] = data_i;
  end
  always_ff @(posedge clk_i) mem_q <= reset_i ? '0 : mem_d;
  assign words_o = mem_q;
endmodule

// File: rtl/mac_array_sequencer.sv
// mac_array_sequencer: loads A/B over bus valid/ready, feeds skewed row/col lanes, drains C over valid/yumi; ports clk_i, reset_i, en_i, busy_o, array_reset_o, bus
module mac_array_sequencer
  import mac_pkg::*;
#(
  parameter int width_p = 32,
  parameter int array_width_p = 2,
  parameter int array_height_p = 2,
  parameter int depth_p = 2
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic en_i,
  output logic busy_o,
  output logic array_reset_o,
  mac_array_sequencer_if.slave bus
);
  localparam int rows = array_height_p;
  localparam int cols = array_width_p;
  localparam int depth = depth_p;
  localparam int n_words = num_operands(rows, cols, depth);
  localparam int n_macs = num_macs(rows, cols);
  localparam int n_steps = num_steps(rows, cols, depth);
  localparam int lw = cnt_width(n_words - 1);
  localparam int tw = cnt_width(n_steps - 1);
  localparam int iw = cnt_width(n_macs - 1);
  localparam logic [lw-1:0] ld_last = lw'(n_words - 1);
  localparam logic [tw-1:0] t_last = tw'(n_steps - 1);
  localparam logic [iw-1:0] i_last = iw'(n_macs - 1);
  state_e state_q, state_d;
  logic [lw-1:0] ld_q, ld_d;
  logic [tw-1:0] t_q, t_d;
  logic [iw-1:0] i_q, i_d;
  logic [width_p*n_words-1:0] words;
  logic [rows-1:0] row_act;
  logic [cols-1:0] col_act;
  logic we, step, feed, in_drain;
  assign feed = state_q == FEED;
  assign in_drain = state_q == DRAIN;
  assign bus.ready_o = state_q == IDLE || state_q == LOAD;
  assign we = bus.valid_i && bus.ready_o && en_i;
  assign busy_o = state_q != IDLE;
  assign array_reset_o = state_q == CLEAR && en_i;
  assign bus.valid_o = in_drain;
  assign bus.data_o = in_drain ? bus.z_i[int'(i_q)*width_p +: width_p] : '0;
  assign bus.z_yumi_o = (in_drain && en_i && bus.yumi_i) ? (n_macs'(1) << i_q) : '0;
  assign bus.row_valid_o = row_act;
  assign bus.col_valid_o = col_act;
  assign step = (&(bus.row_ready_i | ~row_act)) && (&(bus.col_ready_i | ~col_act));
  operand_buffer #(.width_p(width_p), .words_p(n_words), .idx_w_p(lw)) u_buf (
    .clk_i(clk_i),
    .reset_i(reset_i),
    .we_i(we),
    .idx_i(ld_q),
    .data_i(bus.data_i),
    .words_o(words)
  );
  always_comb begin
    row_act = '0;
    col_act = '0;
    bus.row_o = '0;
    bus.col_o = '0;
    for (int r = 0; r < rows; r++)
      if (feed && r <= int'(t_q) && int'(t_q) < r + depth) begin
        row_act[r] = 1'b1;
        bus.row_o[r*width_p +: width_p] = words[(r*depth + int'(t_q) - r)*width_p +: width_p];
      end
    for (int c = 0; c < cols; c++)
      if (feed && c <= int'(t_q) && int'(t_q) < c + depth) begin
        col_act[c] = 1'b1;
        bus.col_o[c*width_p +: width_p] = words[(rows*depth + c*depth + int'(t_q) - c)*width_p +: width_p];
      end
  end
  always_comb begin
    state_d = state_q;
    ld_d = ld_q;
    t_d = t_q;
    i_d = i_q;
    if (we) begin
      ld_d = ld_q == ld_last ? '0 : ld_q + 1'b1;
      state_d = ld_q == ld_last ? FEED : LOAD;
    end
    if (en_i && feed && step) begin
      t_d = t_q == t_last ? '0 : t_q + 1'b1;
      state_d = t_q == t_last ? WAIT : FEED;
    end
    if (en_i && state_q == WAIT && &bus.z_valid_i) state_d = DRAIN;
    if (en_i && in_drain && bus.yumi_i) begin
      i_d = i_q == i_last ? '0 : i_q + 1'b1;
      state_d = i_q == i_last ? CLEAR : DRAIN;
    end
    if (en_i && state_q == CLEAR) state_d = IDLE;
  end
  always_ff @(posedge clk_i) begin
    state_q <= reset_i ? IDLE : state_d;
    ld_q <= reset_i ? '0 : ld_d;
    t_q <= reset_i ? '0 : t_d;
    i_q <= reset_i ? '0 : i_d;
  end
endmodule

// File: tb/tb_mac_array_sequencer.sv
// tb_mac_array_sequencer: directed and randomized jobs against a matrix-product reference and a lane-level array model
module tb_mac_array_sequencer;
  localparam int WD = 32;
  localparam int H = 2;
  localparam int W = 2;
  localparam int K = 2;
  localparam int N = H*K + K*W;
  localparam int M = H*W;
  localparam int S = K + (H > W ? H : W) - 1;
  logic clk = 1'b0;
  logic reset_i, en_i, busy_o, array_reset_o;
  int checks = 0, failures = 0;
  logic [WD-1:0] A [H][K];
  logic [WD-1:0] B [K][W];
  logic [WD-1:0] expc [M];
  logic [WD-1:0] words [N];
  logic [WD-1:0] rowd [H][K];
  logic [WD-1:0] cold [W][K];
  int rc [H];
  int cc [W];
  int g = 0, dcnt = 0, jb = 0, clr_cnt = 0;
  logic [M-1:0] zv = '0;
  logic [WD*M-1:0] zd = '0;
  bit z_hold, rand_rdy;
  logic [H-1:0] rr, rnd_r;
  logic [W-1:0] cr, rnd_c;
  bit fire, v;
  int idx;
  logic [WD-1:0] s;
  logic [WD*H-1:0] row_snap;
  logic [WD*W-1:0] col_snap;
  always #5 clk = ~clk;
  mac_array_sequencer_if #(.width_p(WD), .array_width_p(W), .array_height_p(H)) bus ();
  mac_array_sequencer #(.width_p(WD), .array_width_p(W), .array_height_p(H), .depth_p(K)) dut (
    .clk_i(clk),
    .reset_i(reset_i),
    .en_i(en_i),
    .busy_o(busy_o),
    .array_reset_o(array_reset_o),
    .bus(bus)
  );
  assign bus.z_valid_i = z_hold ? '0 : zv;
  assign bus.z_i = zd;
  assign bus.row_ready_i = rand_rdy ? rnd_r : rr;
  assign bus.col_ready_i = rand_rdy ? rnd_c : cr;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  always @(posedge clk) begin
    #1;
    rnd_r = H'($urandom);
    rnd_c = W'($urandom);
  end
  always @(negedge clk) begin
    if (reset_i || array_reset_o) begin
      g = 0;
      zv = '0;
      zd = '0;
      for (int r = 0; r < H; r++) rc[r] = 0;
      for (int c = 0; c < W; c++) cc[c] = 0;
    end else begin
      fire = en_i && ((|bus.row_valid_o) || (|bus.col_valid_o)) &&
             ((bus.row_valid_o & ~bus.row_ready_i) == '0) && ((bus.col_valid_o & ~bus.col_ready_i) == '0);
      if (fire) begin
        for (int r = 0; r < H; r++) begin
          v = g >= r && g < r + K;
          chk("row_valid", bus.row_valid_o[r], v);
          if (v) chk("row_data", bus.row_o[r*WD +: WD], A[r][g-r]);
          else chk("row_idle_data", bus.row_o[r*WD +: WD], 0);
          if (bus.row_valid_o[r] && rc[r] < K) begin
            rowd[r][rc[r]] = bus.row_o[r*WD +: WD];
            rc[r]++;
          end
        end
        for (int c = 0; c < W; c++) begin
          v = g >= c && g < c + K;
          chk("col_valid", bus.col_valid_o[c], v);
          if (v) chk("col_data", bus.col_o[c*WD +: WD], B[g-c][c]);
          else chk("col_idle_data", bus.col_o[c*WD +: WD], 0);
          if (bus.col_valid_o[c] && cc[c] < K) begin
            cold[c][cc[c]] = bus.col_o[c*WD +: WD];
            cc[c]++;
          end
        end
        g++;
        for (int r = 0; r < H; r++)
          for (int c = 0; c < W; c++)
            if (rc[r] == K && cc[c] == K && !zv[r*W+c]) begin
              s = '0;
              for (int k = 0; k < K; k++) s = s + rowd[r][k] * cold[c][k];
              zd[(r*W+c)*WD +: WD] = s;
              zv[r*W+c] = 1'b1;
            end
      end
    end
    if (!reset_i && bus.valid_o && bus.yumi_i && en_i) begin
      idx = dcnt - jb;
      if (idx < M) begin
        chk("drain_data", bus.data_o, expc[idx]);
        chk("z_yumi", bus.z_yumi_o, M'(1) << idx);
      end else chk("drain_overrun", idx, M - 1);
      dcnt++;
    end else chk("z_yumi_idle", bus.z_yumi_o, 0);
    if (array_reset_o) clr_cnt++;
  end
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic mats(input bit fixed);
    int n;
    logic [WD-1:0] t;
    jb = dcnt;
    for (int r = 0; r < H; r++)
      for (int k = 0; k < K; k++) A[r][k] = fixed ? WD'(r*K + k + 1) : $urandom;
    for (int k = 0; k < K; k++)
      for (int c = 0; c < W; c++) B[k][c] = fixed ? WD'(k*W + c + 5) : $urandom;
    if (fixed) expc = '{32'd19, 32'd22, 32'd43, 32'd50};
    else
      for (int r = 0; r < H; r++)
        for (int c = 0; c < W; c++) begin
          t = '0;
          for (int k = 0; k < K; k++) t = t + A[r][k] * B[k][c];
          expc[r*W+c] = t;
        end
    n = 0;
    for (int r = 0; r < H; r++)
      for (int k = 0; k < K; k++) words[n++] = A[r][k];
    for (int c = 0; c < W; c++)
      for (int k = 0; k < K; k++) words[n++] = B[k][c];
  endtask
  task automatic send(input logic [WD-1:0] w);
    int n = 0;
    bit acc = 0;
    bus.valid_i = 1'b1;
    bus.data_i = w;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = bus.ready_o && en_i;
      cyc();
      n++;
    end
    chk("load_accept", acc, 1);
    bus.valid_i = 1'b0;
  endtask
  task automatic load(input bit throttle);
    for (int n = 0; n < N; n++) begin
      send(words[n]);
      if (throttle) cyc();
    end
  endtask
  task automatic wait_valid();
    int n = 0;
    while (!bus.valid_o && n < 400) begin
      cyc();
      n++;
    end
    chk("valid_o_rise", bus.valid_o, 1);
  endtask
  task automatic wait_g(input int target);
    int n = 0;
    while (g != target && n < 400) begin
      cyc();
      n++;
    end
    chk("feed_step_reached", g, target);
  endtask
  task automatic drain_all();
    int n = 0;
    bus.yumi_i = 1'b1;
    while (dcnt - jb < M && n < 200) begin
      cyc();
      n++;
    end
    bus.yumi_i = 1'b0;
    chk("drain_count", dcnt - jb, M);
  endtask
  task automatic finish_job();
    int c0 = clr_cnt;
    @(negedge clk);
    chk("clear_pulse", array_reset_o, 1);
    chk("ready_in_clear", bus.ready_o, 0);
    repeat (3) cyc();
    chk("clear_once", clr_cnt - c0, 1);
    @(negedge clk);
    chk("idle_busy", busy_o, 0);
    chk("idle_ready", bus.ready_o, 1);
    cyc();
  endtask
  initial begin
    reset_i = 1'b1;
    en_i = 1'b1;
    bus.valid_i = 1'b0;
    bus.data_i = '0;
    bus.yumi_i = 1'b0;
    rr = '1;
    cr = '1;
    z_hold = 0;
    rand_rdy = 0;
    repeat (2) cyc();
    reset_i = 1'b0;
    @(negedge clk);
    chk("rst_ready", bus.ready_o, 1);
    chk("rst_busy", busy_o, 0);
    chk("rst_valid_o", bus.valid_o, 0);
    chk("rst_row_valid", bus.row_valid_o, 0);
    chk("rst_col_valid", bus.col_valid_o, 0);
    chk("rst_array_reset", array_reset_o, 0);
    chk("rst_data_o", bus.data_o, 0);
    chk("rst_row_o", bus.row_o, 0);
    chk("rst_col_o", bus.col_o, 0);
    cyc();
    mats(1);
    load(0);
    wait_valid();
    drain_all();
    finish_job();
    mats(0);
    rr = 2'b01;
    load(0);
    wait_g(1);
    @(negedge clk);
    row_snap = bus.row_o;
    col_snap = bus.col_o;
    for (int n = 0; n < 3; n++) begin
      cyc();
      @(negedge clk);
      chk("stall_row_o", bus.row_o, row_snap);
      chk("stall_col_o", bus.col_o, col_snap);
      chk("stall_step", g, 1);
    end
    cyc();
    rr = '1;
    wait_valid();
    drain_all();
    finish_job();
    mats(0);
    load(0);
    wait_valid();
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      chk("hold_valid_o", bus.valid_o, 1);
      chk("hold_data_o", bus.data_o, expc[0]);
      cyc();
    end
    drain_all();
    finish_job();
    mats(0);
    load(1);
    bus.valid_i = 1'b1;
    bus.data_i = 32'hdead_beef;
    for (int n = 0; n < 400 && !bus.valid_o; n++) begin
      @(negedge clk);
      chk("busy_ready", bus.ready_o, 0);
      cyc();
    end
    drain_all();
    bus.valid_i = 1'b0;
    finish_job();
    mats(0);
    rr = 2'b01;
    load(0);
    wait_g(1);
    reset_i = 1'b1;
    cyc();
    reset_i = 1'b0;
    rr = '1;
    @(negedge clk);
    chk("midrst_busy", busy_o, 0);
    chk("midrst_ready", bus.ready_o, 1);
    chk("midrst_row_valid", bus.row_valid_o, 0);
    chk("midrst_col_valid", bus.col_valid_o, 0);
    chk("midrst_valid_o", bus.valid_o, 0);
    cyc();
    mats(0);
    load(0);
    wait_valid();
    drain_all();
    finish_job();
    mats(0);
    z_hold = 1;
    load(0);
    wait_g(S);
    bus.yumi_i = 1'b1;
    for (int n = 0; n < 2; n++) begin
      @(negedge clk);
      chk("wait_no_valid", bus.valid_o, 0);
      cyc();
    end
    bus.yumi_i = 1'b0;
    en_i = 1'b0;
    z_hold = 0;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      chk("en0_wait_valid", bus.valid_o, 0);
      chk("en0_wait_busy", busy_o, 1);
      cyc();
    end
    en_i = 1'b1;
    wait_valid();
    en_i = 1'b0;
    bus.yumi_i = 1'b1;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      chk("en0_drain_valid", bus.valid_o, 1);
      chk("en0_drain_data", bus.data_o, expc[0]);
      cyc();
    end
    en_i = 1'b1;
    drain_all();
    finish_job();
    rand_rdy = 1;
    for (int j = 0; j < 3; j++) begin
      mats(0);
      load(j % 2 == 1);
      wait_valid();
      drain_all();
      finish_job();
    end
    rand_rdy = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
